// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a byte FIFO, 8N1 framing by default.
//   Optional macro UART_TX_PARITY_EN adds an even-parity bit after the data bits (8E1).
//   Ports:
//     clk        - rising-edge clock
//     rst_n      - asynchronous active-low reset (aborts frame, empties FIFO)
//     tx_data    - byte to enqueue
//     tx_valid   - tx_data valid this cycle
//     tx_ready   - FIFO can accept a byte this cycle
//     tx_enable  - permission to start a new frame; frames in progress ignore it
//     tx         - registered serial line, idle high
//     tx_busy    - FSM not idle or FIFO non-empty
//     fifo_count - current FIFO occupancy
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic                        tx_enable,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CPB - 1);
  localparam logic [AW:0]   FULL       = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY     = 3'd4;
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    head;
  logic          push, pop, can_pop, bit_done, last_bit;

  assign tx_ready   = count_q != FULL;
  assign push       = tx_valid & tx_ready;
  assign can_pop    = (count_q != '0) & tx_enable;
  assign bit_done   = cnt_q == '0;
  // A pop happens only when a new frame begins: from IDLE, or back-to-back at the end of STOP.
  assign pop        = can_pop & ((state_q == IDLE) | ((state_q == STOP) & bit_done));
  assign head       = mem_q[rd_q];
  assign tx         = tx_q;
  assign tx_busy    = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  assign par_d    = pop ? ^head : par_q;
  assign last_bit = par_q;
`else
  assign last_bit = 1'b1;
`endif

  always_comb begin
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = can_pop ? START : IDLE;
      START:   state_d = bit_done ? DATA : START;
      DATA:    state_d = (bit_done && idx_q == 3'd7) ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
      PARITY:  state_d = bit_done ? STOP : PARITY;
`endif
      STOP:    state_d = bit_done ? (can_pop ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
  end

  // tx_d is the line value for the upcoming bit period; the line is registered so it changes on the boundary edge.
  always_comb begin
    cnt_d = (state_d == IDLE) ? '0 : bit_done ? CNT_RELOAD : cnt_q - CW'(1);
    idx_d = (state_q == DATA && bit_done) ? idx_q + 3'd1 : idx_q;
    sh_d  = pop ? head : (state_q == DATA && bit_done) ? sh_q >> 1 : sh_q;
    tx_d  = (state_d == IDLE) ? 1'b1 :
            pop               ? 1'b0 :
            !bit_done         ? tx_q :
            (state_q == START) ? sh_q[0] :
            (state_q == DATA)  ? ((idx_q == 3'd7) ? last_bit : sh_q[1]) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end

  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= tx_data;
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), minimum 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, byte buffer entries, power of two, 2..16.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port tx_data, input, 8, byte to transmit.
REQ-007 SHALL have port tx_valid, input, 1, tx_data valid this cycle.
REQ-008 SHALL have port tx_ready, output, 1, FIFO can accept a byte this cycle.
REQ-009 SHALL have port tx_enable, input, 1, permission to start a new frame; frames in progress ignore it.
REQ-010 SHALL have port tx, output, 1, registered serial line, idle high.
REQ-011 SHALL have port tx_busy, output, 1, high while the FSM is not IDLE or the FIFO is non-empty.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-013 SHALL write tx_data into the FIFO on each rising edge with tx_valid=1 and tx_ready=1; tx_ready = (fifo_count != FIFO_DEPTH).
REQ-014 SHALL ignore tx_valid while tx_ready=0; no overwrite, no error flag.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY (present only when the parity option is compiled in), and STOP.
REQ-016 In IDLE, with FIFO non-empty and tx_enable=1, SHALL pop the head byte into an 8-bit shift register, drive tx=0, and enter START on the same edge.
REQ-017 SHALL hold each line bit for exactly CLKS_PER_BIT cycles, using a down-counter reloaded to CLKS_PER_BIT-1 at each bit boundary.
REQ-018 START→DATA: SHALL send 8 data bits LSB first, tracked by a 3-bit index that wraps 7→0 on exit from DATA.
REQ-019 DATA→STOP, or DATA→PARITY→STOP: STOP SHALL drive tx=1 for one bit period.
REQ-020 On the last STOP cycle, with FIFO non-empty and tx_enable=1, SHALL pop the next byte and go directly to START with zero idle cycles; otherwise SHALL go to IDLE.
REQ-021 A byte written into an empty FIFO while in IDLE with tx_enable=1 SHALL produce tx falling at the rising edge after the write edge (1-cycle latency).
REQ-022 On a simultaneous push and pop in the same cycle, fifo_count SHALL be unchanged and data order SHALL be preserved (FIFO, no bypass).
REQ-023 Deasserting tx_enable mid-frame SHALL NOT truncate the frame; it blocks only the next pop.
REQ-024 Unreachable state encodings SHALL return to IDLE with tx=1.

Reset
REQ-025 While rst_n=0, SHALL force tx=1, state=IDLE, FIFO empty (fifo_count=0, tx_ready=1), counter=0, and bit index=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately and discard all buffered bytes; tx SHALL be high asynchronously.
REQ-027 After reset release, SHALL NOT start a frame until a byte is written.

Configuration
REQ-028 With macro UART_TX_PARITY_EN defined, SHALL insert a PARITY state after DATA transmitting even parity (XOR of the 8 data bits) for one bit period; frame = 11 bit periods.
REQ-029 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; frame = 10 bit periods (8N1).

Verification
REQ-030 CLK_FREQ=16, BAUD_RATE=1 (CLKS_PER_BIT=16), write 0xA5 while idle → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 cycles, tx low 1 cycle after the write.
REQ-031 Write 0x00, 0xFF back-to-back → 20 contiguous bit periods, no idle gap between the STOP and START bits; tx_busy stays high throughout.
REQ-032 Hold tx_enable=0 and write 5 bytes with FIFO_DEPTH=4 → fifo_count=4, tx_ready=0, 5th byte dropped; raise tx_enable → exactly the 4 bytes go out, in order.
REQ-033 Assert rst_n=0 during DATA bit 3 → tx=1 immediately, fifo_count=0; no further transitions until a new write.
REQ-034 With UART_TX_PARITY_EN defined, write 0x07 → parity bit 1; write 0x03 → parity bit 0; each frame 11 bit periods.
REQ-035 Drop tx_enable during the START bit → current frame completes; a queued byte is held until tx_enable=1.
